lab5_mux_arbiter: RTL and testbench

- Round-robin arbiter that shares one 2-to-1 multiplexed output channel between two requesters.
- Each requester presents data and a request; the block drives the mux select, per-requester grants and an output-valid flag.
- Sits in front of the 2-to-1 mux datapath in the Lab 5 computer-architecture design and is the only block that drives its select.
- Limits any single grant to MAX_HOLD cycles while the other side is waiting.

---
 rtl/lab5_mux_arbiter.sv | 152 +++++++++++++++
 tb/tb_lab5_mux_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab5_mux_arbiter.sv
// -----------------------------------------------------------------------------
// lab5_mux_arbiter
//
// Purpose:
//   Round-robin arbiter that shares one 2-to-1 multiplexed output channel
//   between two requesters. It owns the mux select for the Lab 5 datapath.
//   While the other requester is waiting, no grant lasts more than MAX_HOLD
//   consecutive cycles. A lone requester keeps the channel indefinitely.
//
// Parameters:
//   WIDTH    - data width of D0, D1 and Y
//   MAX_HOLD - maximum consecutive grant cycles while the other side waits (>= 1)
//
// Ports:
//   CLK      in   system clock, rising-edge active
//   RESET_N  in   asynchronous active-low reset
//   REQ0     in   request from requester 0 (level, held while wanted)
//   REQ1     in   request from requester 1
//   D0       in   [WIDTH] data from requester 0
//   D1       in   [WIDTH] data from requester 1
//   GNT0     out  grant to requester 0 (registered)
//   GNT1     out  grant to requester 1 (registered)
//   S        out  mux select, 0 = D0, 1 = D1 (registered)
//   VALID    out  channel owned this cycle (registered)
//   Y        out  [WIDTH] shared channel output (combinational from S/VALID)
// -----------------------------------------------------------------------------
module lab5_mux_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  output logic             GNT0,
  output logic             GNT1,
  output logic             S,
  output logic             VALID,
  output logic [WIDTH-1:0] Y
);

  // Hold counter is at least one bit wide so MAX_HOLD=1 still elaborates.
  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic            last_q,  last_d;
  logic            gnt0_q,  gnt0_d;
  logic            gnt1_q,  gnt1_d;
  logic            s_q,     s_d;
  logic            valid_q, valid_d;

  // Next-state logic: all decisions use registered state plus REQ at the edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (REQ0 && REQ1) begin
          // LAST=1 means requester 1 was served most recently, so 0 wins.
          state_d = last_q ? GRANT0 : GRANT1;
        end else if (REQ0) begin
          state_d = GRANT0;
        end else if (REQ1) begin
          state_d = GRANT1;
        end
      end
      GRANT0: begin
        if (!REQ0) begin
          state_d = REQ1 ? GRANT1 : IDLE;
        end else if (REQ1 && (cnt_q == CNT_MAX)) begin
          state_d = GRANT1;
        end
      end
      GRANT1: begin
        if (!REQ1) begin
          state_d = REQ0 ? GRANT0 : IDLE;
        end else if (REQ0 && (cnt_q == CNT_MAX)) begin
          state_d = GRANT0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Hold count and round-robin pointer.
  always_comb begin
    cnt_d  = '0;
    last_d = last_q;
    if ((state_d != IDLE) && (state_d == state_q)) begin
      // Staying in the same grant: count up, saturating so a lone
      // requester is never forced off the channel.
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
    if ((state_d == GRANT0) && (state_q != GRANT0)) begin
      last_d = 1'b0;
    end else if ((state_d == GRANT1) && (state_q != GRANT1)) begin
      last_d = 1'b1;
    end
  end

  // Outputs are decoded from the next state so they appear right after the
  // edge that samples the request; S keeps its value while idle.
  always_comb begin
    gnt0_d  = (state_d == GRANT0);
    gnt1_d  = (state_d == GRANT1);
    valid_d = (state_d != IDLE);
    s_d     = s_q;
    if (state_d == GRANT0) begin
      s_d = 1'b0;
    end else if (state_d == GRANT1) begin
      s_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      s_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      s_q     <= s_d;
      valid_q <= valid_d;
    end
  end

  assign GNT0  = gnt0_q;
  assign GNT1  = gnt1_q;
  assign S     = s_q;
  assign VALID = valid_q;

  // Data path is combinational so requester data changes reach Y at once.
  assign Y = valid_q ? (s_q ? D1 : D0) : '0;

endmodule

// File: tb/tb_lab5_mux_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lab5_mux_arbiter
//
// Drives two arbiter instances with shared stimulus: one with MAX_HOLD=4 and
// one with MAX_HOLD=1, both WIDTH=4. Expected outputs come from an
// owner/held-cycles model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_lab5_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [3:0] d0, d1;

  logic       a_gnt0, a_gnt1, a_s, a_valid;
  logic [3:0] a_y;
  logic       b_gnt0, b_gnt1, b_s, b_valid;
  logic [3:0] b_y;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lab5_mux_arbiter #(.WIDTH(4), .MAX_HOLD(4)) dut_a (
    .CLK(clk), .RESET_N(rst_n), .REQ0(req0), .REQ1(req1), .D0(d0), .D1(d1),
    .GNT0(a_gnt0), .GNT1(a_gnt1), .S(a_s), .VALID(a_valid), .Y(a_y)
  );

  lab5_mux_arbiter #(.WIDTH(4), .MAX_HOLD(1)) dut_b (
    .CLK(clk), .RESET_N(rst_n), .REQ0(req0), .REQ1(req1), .D0(d0), .D1(d1),
    .GNT0(b_gnt0), .GNT1(b_gnt1), .S(b_s), .VALID(b_valid), .Y(b_y)
  );

  // Reference model: index 0 models dut_a, index 1 models dut_b.
  int owner_m [2];   // -1 none, else requester holding the channel
  int held_m  [2];   // cycles the current owner has held it
  int pref_m  [2];   // who wins a tie from idle
  bit s_m     [2];
  int mh      [2] = '{4, 1};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      owner_m[i] = -1;
      held_m[i]  = 0;
      pref_m[i]  = 0;
      s_m[i]     = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int o, n;
      bit r_own, r_oth;
      o = owner_m[i];
      if (o < 0) begin
        if (req0 && req1) n = pref_m[i];
        else if (req0)    n = 0;
        else if (req1)    n = 1;
        else              n = -1;
      end else begin
        r_own = (o == 0) ? req0 : req1;
        r_oth = (o == 0) ? req1 : req0;
        if (!r_own)                          n = r_oth ? 1 - o : -1;
        else if (r_oth && held_m[i] >= mh[i]) n = 1 - o;
        else                                 n = o;
      end
      if (n >= 0 && n == o) held_m[i] = held_m[i] + 1;
      else if (n >= 0)      held_m[i] = 1;
      else                  held_m[i] = 0;
      if (n >= 0 && n != o) pref_m[i] = 1 - n;
      if (n >= 0)           s_m[i] = (n == 1);
      owner_m[i] = n;
    end
  endtask

  // Expected {GNT0, GNT1, S, VALID, Y} for model i with current data inputs.
  function automatic logic [7:0] exp_vec(int i);
    logic       v;
    logic [3:0] y;
    v = (owner_m[i] >= 0);
    y = v ? (s_m[i] ? d1 : d0) : 4'h0;
    return {owner_m[i] == 0, owner_m[i] == 1, s_m[i], v, y};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    $display("t=%0t req=%b%b d0=%h d1=%h | A g=%b%b s=%b v=%b y=%h | B g=%b%b s=%b v=%b y=%h",
             $time, req0, req1, d0, d1, a_gnt0, a_gnt1, a_s, a_valid, a_y,
             b_gnt0, b_gnt1, b_s, b_valid, b_y);
  endtask

  // Short reset pulse placed mid-cycle, no clock edge inside it.
  task automatic apply_reset();
    req0 = 1'b0;
    req1 = 1'b0;
    #1 rst_n = 1'b0;
    model_reset();
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    d0    = 4'h3;
    d1    = 4'hC;
    model_reset();
    #2;
    vectors++;
    if ({a_gnt0, a_gnt1, a_s, a_valid, a_y} !== 8'h00) begin
      $display("FAIL reset_a: got %b expected %b", {a_gnt0, a_gnt1, a_s, a_valid, a_y}, 8'h00);
      miscompares++;
    end
    vectors++;
    if ({b_gnt0, b_gnt1, b_s, b_valid, b_y} !== 8'h00) begin
      $display("FAIL reset_b: got %b expected %b", {b_gnt0, b_gnt1, b_s, b_valid, b_y}, 8'h00);
      miscompares++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vectors++;
    if ({a_gnt0, a_gnt1, a_s, a_valid, a_y} !== exp_vec(0)) begin
      $display("FAIL idle_after_reset: got %b expected %b", {a_gnt0, a_gnt1, a_s, a_valid, a_y}, exp_vec(0));
      miscompares++;
    end
  endtask

  task automatic test_single();
    apply_reset();
    req0 = 1'b1;
    d0   = 4'hA;
    tick();
    vectors++;
    if ({a_gnt0, a_gnt1, a_s, a_valid, a_y} !== 8'b1001_1010) begin
      $display("FAIL single_grant: got %b expected %b", {a_gnt0, a_gnt1, a_s, a_valid, a_y}, 8'b1001_1010);
      miscompares++;
    end
    d0 = 4'h5;
    #1;
    vectors++;
    if (a_y !== 4'h5) begin
      $display("FAIL single_comb_y: got %h expected %h", a_y, 4'h5);
      miscompares++;
    end
    req0 = 1'b0;
    tick();
    vectors++;
    if ({a_gnt0, a_valid, a_y} !== 6'b00_0000) begin
      $display("FAIL single_release: got %b expected %b", {a_gnt0, a_valid, a_y}, 6'b0);
      miscompares++;
    end
  endtask

  task automatic test_contention();
    apply_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      logic e0;
      tick();
      e0 = (((c - 1) / 4) % 2) == 0;
      vectors++;
      if ({a_gnt0, a_gnt1} !== {e0, ~e0}) begin
        $display("FAIL contention_c%0d: got g=%b%b expected %b%b", c, a_gnt0, a_gnt1, e0, ~e0);
        miscompares++;
      end
      vectors++;
      if ({b_gnt0, b_gnt1, b_s, b_valid, b_y} !== exp_vec(1)) begin
        $display("FAIL contention_b_c%0d: got %b expected %b", c, {b_gnt0, b_gnt1, b_s, b_valid, b_y}, exp_vec(1));
        miscompares++;
      end
    end
  endtask

  task automatic test_lone_hold();
    apply_reset();
    req1 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      vectors++;
      if ({a_gnt0, a_gnt1, a_s, a_valid} !== 4'b0111) begin
        $display("FAIL lone_hold_c%0d: got %b expected %b", c, {a_gnt0, a_gnt1, a_s, a_valid}, 4'b0111);
        miscompares++;
      end
    end
    req0 = 1'b1;
    tick();
    vectors++;
    if ({a_gnt0, a_gnt1, a_s} !== 3'b100) begin
      $display("FAIL lone_takeover: got %b expected %b", {a_gnt0, a_gnt1, a_s}, 3'b100);
      miscompares++;
    end
  endtask

  task automatic test_early_release();
    apply_reset();
    d0   = 4'h6;
    d1   = 4'h9;
    req0 = 1'b1;
    tick();
    tick();
    req1 = 1'b1;
    tick();
    vectors++;
    if ({a_gnt0, a_valid} !== 2'b11) begin
      $display("FAIL early_hold: got %b expected %b", {a_gnt0, a_valid}, 2'b11);
      miscompares++;
    end
    req0 = 1'b0;
    tick();
    vectors++;
    if ({a_gnt0, a_gnt1, a_s, a_valid, a_y} !== 8'b0111_1001) begin
      $display("FAIL early_handover: got %b expected %b", {a_gnt0, a_gnt1, a_s, a_valid, a_y}, 8'b0111_1001);
      miscompares++;
    end
  endtask

  task automatic test_max_hold1();
    apply_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      logic es;
      tick();
      es = (c % 2) == 1;
      vectors++;
      if ({b_s, b_valid, b_gnt0 & b_gnt1} !== {es, 1'b1, 1'b0}) begin
        $display("FAIL maxhold1_c%0d: got s/v/both=%b expected %b", c, {b_s, b_valid, b_gnt0 & b_gnt1}, {es, 2'b10});
        miscompares++;
      end
    end
  endtask

  task automatic test_async_reset();
    req0 = 1'b0;
    req1 = 1'b1;
    tick();
    tick();
    vectors++;
    if (a_gnt1 !== 1'b1) begin
      $display("FAIL async_setup: got gnt1=%b expected 1", a_gnt1);
      miscompares++;
    end
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({a_gnt0, a_gnt1, a_s, a_valid, a_y} !== 8'h00) begin
      $display("FAIL async_clear_a: got %b expected %b", {a_gnt0, a_gnt1, a_s, a_valid, a_y}, 8'h00);
      miscompares++;
    end
    vectors++;
    if ({b_gnt0, b_gnt1, b_s, b_valid, b_y} !== 8'h00) begin
      $display("FAIL async_clear_b: got %b expected %b", {b_gnt0, b_gnt1, b_s, b_valid, b_y}, 8'h00);
      miscompares++;
    end
    req0 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vectors++;
    if ({a_gnt0, a_gnt1} !== 2'b10) begin
      $display("FAIL async_release: got %b expected %b", {a_gnt0, a_gnt1}, 2'b10);
      miscompares++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      req0 = 1'($urandom_range(0, 1));
      req1 = 1'($urandom_range(0, 1));
      d0   = 4'($urandom);
      d1   = 4'($urandom);
      tick();
      vectors++;
      if ({a_gnt0, a_gnt1, a_s, a_valid, a_y} !== exp_vec(0)) begin
        $display("FAIL random_a_%0d: got %b expected %b", c, {a_gnt0, a_gnt1, a_s, a_valid, a_y}, exp_vec(0));
        miscompares++;
      end
      vectors++;
      if ({b_gnt0, b_gnt1, b_s, b_valid, b_y} !== exp_vec(1)) begin
        $display("FAIL random_b_%0d: got %b expected %b", c, {b_gnt0, b_gnt1, b_s, b_valid, b_y}, exp_vec(1));
        miscompares++;
      end
      // Mid-cycle data change must reach Y without a clock edge.
      d0 = 4'($urandom);
      d1 = 4'($urandom);
      #1;
      vectors++;
      if (a_y !== exp_vec(0)[3:0]) begin
        $display("FAIL random_comb_y_%0d: got %h expected %h", c, a_y, exp_vec(0)[3:0]);
        miscompares++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_lone_hold();
    test_early_release();
    test_max_hold1();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
